// File: rtl/chunked_addsub.sv
// chunked_addsub
//   Multi-cycle WIDTH-bit add/subtract unit. Processes CHUNK bits per clock,
//   LSB chunk first, and publishes the registered result and flags on the
//   final chunk edge together with a one-cycle done pulse.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits per cycle; must divide WIDTH. N = WIDTH/CHUNK compute cycles.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      request, accepted only while o_busy = 0
//   i_sub        0: A+B, 1: A-B (sampled with start)
//   i_acc        1: use current o_sum as A (sampled with start)
//   i_a, i_b     operands (sampled with start)
//   o_busy       high while chunks are being processed
//   o_done       single-cycle pulse when the result is updated
//   o_sum        wrap-around result
//   o_carry      carry out of MSB (subtract: 1 = no borrow)
//   o_overflow   signed overflow
module chunked_addsub #(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic             i_acc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_part;
    logic             r_cy;
    logic [CW-1:0]    r_cnt;

    // Operands shift right one chunk per cycle, so the live chunk is always
    // the low CHUNK bits; no variable part-select mux is needed.
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_csum;
    logic [WIDTH-1:0] w_part_next;
    logic             w_cin_msb;

    assign w_a_chunk = r_opa[CHUNK-1:0];
    assign w_b_chunk = r_opb[CHUNK-1:0];
    assign w_csum    = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_cy};

    // Carry into the top bit of this chunk, recovered from the sum bit.
    // On the last chunk this is the carry into the result MSB.
    assign w_cin_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_csum[CHUNK-1];

    // Partial result fills from the top; after N shifts it is fully aligned.
    generate
        if (CHUNK == WIDTH) begin : g_single
            logic w_unused_part;
            assign w_unused_part = ^r_part;
            assign w_part_next   = w_csum[CHUNK-1:0];
        end else begin : g_multi
            assign w_part_next = {w_csum[CHUNK-1:0], r_part[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_opa      <= '0;
            r_opb      <= '0;
            r_part     <= '0;
            r_cy       <= 1'b0;
            r_cnt      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_sum      <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_opa   <= i_acc ? o_sum : i_a;
                        r_opb   <= i_sub ? ~i_b : i_b;
                        r_cy    <= i_sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        o_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_opa  <= r_opa >> CHUNK;
                    r_opb  <= r_opb >> CHUNK;
                    r_part <= w_part_next;
                    r_cy   <= w_csum[CHUNK];
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        o_sum      <= w_part_next;
                        o_carry    <= w_csum[CHUNK];
                        o_overflow <= w_cin_msb ^ w_csum[CHUNK];
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Parametrised, multi-cycle add/subtract unit for the calculator datapath and the successor to the fixed 6-bit ripple adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with a start/busy/done handshake. Results and flags are registered. An accumulate mode lets chained calculator operations reuse the previous result as operand A.

## Interface
- WIDTH, 6: operand/result width in bits; must be ≥ 2.
- CHUNK, 2: bits processed per cycle; must divide WIDTH. N = WIDTH/CHUNK is the number of compute cycles.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- acc  input  1  1 = use the current sum output as A instead of port a; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while chunks are being processed.
- done  output  1  single-cycle pulse when the result is updated.
- sum  output  WIDTH  result, two's-complement wrap-around.
- carry  output  1  carry out of the MSB; for subtraction 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE (busy=0) and RUN (busy=1). done is a registered pulse, not a separate state.
- On a clock edge in IDLE with start=1:
  - Latch opA = acc ? sum : a.
  - Latch opB = sub ? ~b : b.
  - Set the running carry to sub, clear the chunk counter to 0, and enter RUN.
- In RUN, on each edge:
  - Chunk k = bits [k·CHUNK+CHUNK−1 : k·CHUNK] of opA + opB + running carry go into the internal partial register.
  - The running carry takes the chunk carry out, and the counter increments.
  - The unit records the carry into the MSB (bit WIDTH−1) when chunk N−1 is processed.
- On the edge that processes chunk N−1:
  - Move the full partial result to sum, the final carry to carry, and c_in(MSB) XOR c_out(MSB) to overflow.
  - Pulse done=1 and return to IDLE.
- sum, carry and overflow change only on that completing edge, or on reset. Between operations they hold their values.
- start while busy=1 is ignored: no queueing, and the operation in flight is unaffected.
- start in the cycle where done=1 is accepted, since busy=0 then. Back-to-back operations are legal.
- With acc=1 and start in the done=1 cycle, A is the just-updated sum.
- The internal partial register and counter are not visible on any port.

## Timing
- Reset values: busy=0, done=0, sum=0, carry=0, overflow=0, state IDLE, counter 0.
- rst asserted mid-operation aborts the operation in flight. The next cycle shows the reset values, and no done pulse is produced.
- rst has priority over start in the same cycle.
- Latency: if start is accepted at edge E0, then:
  - busy=1 after E0 through edge EN−1.
  - After edge EN, done=1 for exactly one cycle with a valid sum, carry and overflow, and busy=0.
  - The result is visible N cycles after the accepting edge.
- Throughput: one operation per N cycles with back-to-back starts.
- With CHUNK=WIDTH (N=1): busy pulses for one cycle and done follows the next cycle.
- Inputs a, b, sub and acc are don't-care except in the cycle start is accepted.

## Test plan
With WIDTH=6 and CHUNK=2 (N=3) unless stated:
- Reset, then a=5, b=3, sub=0 with start → busy high 3 cycles, then done pulse; sum=8, carry=0, overflow=0.
- a=31, b=1, sub=0 → sum=32, carry=0, overflow=1. Then a=63, b=1 → sum=0, carry=1, overflow=0.
- a=0, b=1, sub=1 → sum=63, carry=0 (borrow), overflow=0. Then a=32, b=1, sub=1 → sum=31, carry=1, overflow=1.
- Accumulate chain:
  - a=8, b=0 gives sum=8.
  - Next, acc=1, a=55, b=2 with start in the done cycle → sum=10 (port a ignored).
  - Next, acc=1, b=4, sub=1 → sum=6.
- Start pulsed during cycle 2 of a busy operation with a=5, b=3 → ignored and only one done pulse appears. Separately, rst asserted in busy cycle 2 → next cycle all outputs zero and no done pulse.
- Rerun the first and third scenarios with CHUNK=1 (N=6) and CHUNK=6 (N=1) → identical sums and flags; done latency 6 and 1 cycles respectively.
